// File: rtl/vram_scroller_pkg.sv
// Shared constants, command/state encodings and command validation for the
// text-mode VRAM scroller.
package vram_scroller_pkg;

  localparam int ROWS_MAX      = 38;
  localparam int CHARS_PER_ROW = 80;

  typedef enum logic [1:0] {
    OP_SCROLL     = 2'b00,
    OP_CLR_ROW    = 2'b01,
    OP_CLR_REGION = 2'b10,
    OP_RSVD       = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_NEXT    = 3'd5,
    ST_FIN     = 3'd6
  } state_t;

  // A single-row clear only looks at top_row; region commands need an
  // ordered region that lies inside the screen.
  function automatic logic cmd_is_bad(input cmd_op_t op, input logic [5:0] top,
                                      input logic [5:0] bot);
    logic bad;
    case (op)
      OP_CLR_ROW:               bad = (top >= 6'(ROWS_MAX));
      OP_SCROLL, OP_CLR_REGION: bad = (top > bot) || (bot >= 6'(ROWS_MAX));
      default:                  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/vram_addr_gen.sv
// Row/word position counters and the matching byte addresses of the
// destination word (row r) and the scroll source word (row r+1).
module vram_addr_gen
  import vram_scroller_pkg::*;
#(
  parameter logic [15:0] BASE_ADR  = 16'h0000,
  parameter int          ROW_WORDS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [5:0]  load_row,
  input  logic        inc,
  output logic [5:0]  row,
  output logic [5:0]  word,
  output logic        last_word,
  output logic [15:0] dst_adr,
  output logic [15:0] src_adr
);

  logic [5:0]  row_reg;
  logic [5:0]  word_reg;
  logic [15:0] row_off;
  logic [15:0] word_off;

  assign row       = row_reg;
  assign word      = word_reg;
  assign last_word = (word_reg == 6'(ROW_WORDS - 1));

  // r*80 = r*64 + r*16; word k sits at byte offset 2k. All sums wrap at 16 bits.
  assign row_off  = ({10'd0, row_reg} << 6) + ({10'd0, row_reg} << 4);
  assign word_off = {9'd0, word_reg, 1'b0};
  assign dst_adr  = BASE_ADR + row_off + word_off;
  assign src_adr  = dst_adr + 16'(CHARS_PER_ROW);

  // Word counter walks a row, then rolls over into the next row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_reg  <= '0;
      word_reg <= '0;
    end else if (load) begin
      row_reg  <= load_row;
      word_reg <= '0;
    end else if (inc) begin
      if (last_word) begin
        word_reg <= '0;
        row_reg  <= row_reg + 6'd1;
      end else begin
        word_reg <= word_reg + 6'd1;
      end
    end
  end

endmodule

// File: rtl/vram_scroller.sv
// Wishbone-master text scroller: scrolls a row region up by one row or clears
// rows with a fill character, one 16-bit bus cycle per word.
module vram_scroller
  import vram_scroller_pkg::*;
#(
  parameter logic [15:0] BASE_ADR  = 16'h0000,
  parameter int          ROW_WORDS = 40
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  top_row,
  input  logic [5:0]  bot_row,
  input  logic [7:0]  fill_char,
  output logic        done,
  output logic        err,
  output logic [15:0] m_adr_o,
  output logic [15:0] m_dat_o,
  input  logic [15:0] m_dat_i,
  output logic [1:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i
);

  state_t      state_reg, state_next;
  cmd_op_t     op_reg, op_next;
  logic [5:0]  top_reg, top_next;
  logic [5:0]  bot_reg, bot_next;
  logic [7:0]  fill_reg, fill_next;
  logic        bad_reg, bad_next;
  logic [15:0] data_reg, data_next;
  logic        cyc_reg, cyc_next;
  logic        stb_reg, stb_next;
  logic        we_reg, we_next;
  logic [1:0]  sel_reg, sel_next;
  logic [15:0] adr_reg, adr_next;
  logic [15:0] dat_reg, dat_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  logic        ctr_load, ctr_inc;
  logic [5:0]  row, word;
  logic        last_word;
  logic [15:0] dst_adr, src_adr;
  logic        copy_phase;
  logic        is_last;

  vram_addr_gen #(
    .BASE_ADR (BASE_ADR),
    .ROW_WORDS(ROW_WORDS)
  ) u_addr_gen (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (ctr_load),
    .load_row (top_row),
    .inc      (ctr_inc),
    .row      (row),
    .word     (word),
    .last_word(last_word),
    .dst_adr  (dst_adr),
    .src_adr  (src_adr)
  );

  // A scroll copies rows until the counter reaches bot_row, which is then filled.
  assign copy_phase = (op_reg == OP_SCROLL) && (row != bot_reg);
  assign is_last    = last_word &&
                      (row == ((op_reg == OP_CLR_ROW) ? top_reg : bot_reg));

  assign cmd_ready = (state_reg == ST_IDLE);
  assign m_cyc_o   = cyc_reg;
  assign m_stb_o   = stb_reg;
  assign m_we_o    = we_reg;
  assign m_sel_o   = sel_reg;
  assign m_adr_o   = adr_reg;
  assign m_dat_o   = dat_reg;
  assign done      = done_reg;
  assign err       = err_reg;

  // Next-state and registered-output logic; bus outputs only change on edges.
  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    top_next   = top_reg;
    bot_next   = bot_reg;
    fill_next  = fill_reg;
    bad_next   = bad_reg;
    data_next  = data_reg;
    cyc_next   = cyc_reg;
    stb_next   = stb_reg;
    we_next    = we_reg;
    sel_next   = sel_reg;
    adr_next   = adr_reg;
    dat_next   = dat_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    ctr_load   = 1'b0;
    ctr_inc    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_next    = cmd_op_t'(cmd_op);
          top_next   = top_row;
          bot_next   = bot_row;
          fill_next  = fill_char;
          bad_next   = cmd_is_bad(cmd_op_t'(cmd_op), top_row, bot_row);
          ctr_load   = 1'b1;
          state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (bad_reg) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          state_next = ST_FIN;
        end else begin
          state_next = copy_phase ? ST_RD : ST_WR;
        end
      end
      ST_RD: begin
        cyc_next   = 1'b1;
        stb_next   = 1'b1;
        we_next    = 1'b0;
        sel_next   = 2'b11;
        adr_next   = src_adr;
        state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (m_ack_i) begin
          data_next  = m_dat_i;
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          sel_next   = 2'b00;
          state_next = ST_WR;
        end
      end
      ST_WR: begin
        cyc_next   = 1'b1;
        stb_next   = 1'b1;
        we_next    = 1'b1;
        sel_next   = 2'b11;
        adr_next   = dst_adr;
        dat_next   = copy_phase ? data_reg : {fill_reg, fill_reg};
        state_next = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (m_ack_i) begin
          cyc_next = 1'b0;
          stb_next = 1'b0;
          we_next  = 1'b0;
          sel_next = 2'b00;
          if (is_last) begin
            done_next  = 1'b1;
            state_next = ST_FIN;
          end else begin
            ctr_inc    = 1'b1;
            state_next = ST_NEXT;
          end
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any bus cycle immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg <= ST_IDLE;
      op_reg    <= OP_SCROLL;
      top_reg   <= '0;
      bot_reg   <= '0;
      fill_reg  <= '0;
      bad_reg   <= 1'b0;
      data_reg  <= '0;
      cyc_reg   <= 1'b0;
      stb_reg   <= 1'b0;
      we_reg    <= 1'b0;
      sel_reg   <= 2'b00;
      adr_reg   <= '0;
      dat_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      top_reg   <= top_next;
      bot_reg   <= bot_next;
      fill_reg  <= fill_next;
      bad_reg   <= bad_next;
      data_reg  <= data_next;
      cyc_reg   <= cyc_next;
      stb_reg   <= stb_next;
      we_reg    <= we_next;
      sel_reg   <= sel_next;
      adr_reg   <= adr_next;
      dat_reg   <= dat_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

endmodule

// File: tb/tb_vram_scroller.sv
// Randomized scoreboard bench for vram_scroller with a Wishbone memory slave.
module tb_vram_scroller;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int          RW   = 40;
  localparam int          NWORDS = 1600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [5:0]  top_row = '0;
  logic [5:0]  bot_row = '0;
  logic [7:0]  fill_char = '0;
  logic        done, err;
  logic [15:0] m_adr_o, m_dat_o;
  logic [15:0] m_dat_i;
  logic [1:0]  m_sel_o;
  logic        m_we_o, m_cyc_o, m_stb_o;
  logic        m_ack_i;

  vram_scroller #(.BASE_ADR(BASE), .ROW_WORDS(RW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .top_row  (top_row),
    .bot_row  (bot_row),
    .fill_char(fill_char),
    .done     (done),
    .err      (err),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_dat_i  (m_dat_i),
    .m_sel_o  (m_sel_o),
    .m_we_o   (m_we_o),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_ack_i  (m_ack_i)
  );

  always #5 clk = ~clk;

  int unsigned cyc_count = 0;
  always @(posedge clk) cyc_count <= cyc_count + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- Wishbone memory slave ----------------
  logic [15:0] smem [0:32767];
  int fixed_lat = 0;
  bit rand_lat  = 1'b0;
  int rand_val  = 0;
  int lat_cnt   = 0;

  // Reset also reloads the screen pattern: row r holds {r, r} in every word.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack_i <= 1'b0;
      m_dat_i <= '0;
      lat_cnt <= 0;
      for (int i = 0; i < NWORDS; i++) smem[i] <= {2{8'(i / RW)}};
    end else begin
      m_ack_i <= 1'b0;
      if (m_cyc_o && m_stb_o && !m_ack_i) begin
        if (lat_cnt >= (rand_lat ? rand_val : fixed_lat)) begin
          m_ack_i <= 1'b1;
          lat_cnt <= 0;
          if (m_we_o) smem[m_adr_o[15:1]] <= m_dat_o;
          else m_dat_i <= smem[m_adr_o[15:1]];
          rand_val <= $urandom_range(0, 3);
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end
  end

  // ---------------- Reference model + scoreboard ----------------
  typedef struct {
    bit          we;
    logic [15:0] adr;
    logic [15:0] dat;
  } bus_t;

  bus_t        exp_bus[$];
  bit          exp_err[$];
  logic [15:0] model_mem [0:32767];

  function automatic logic [15:0] word_adr(input int r, input int k);
    return 16'(BASE + r * 80 + 2 * k);
  endfunction

  task automatic model_preload();
    for (int i = 0; i < NWORDS; i++) model_mem[i] = {2{8'(i / RW)}};
  endtask

  task automatic push_wr(input int r, input int k, input logic [15:0] d);
    logic [15:0] a;
    a = word_adr(r, k);
    exp_bus.push_back('{1'b1, a, d});
    model_mem[a[15:1]] = d;
  endtask

  // Expected bus traffic and memory effect of one command.
  task automatic model_cmd(input logic [1:0] op, input int t, input int b,
                           input logic [7:0] f, output int n_rd, output int n_wr,
                           output bit bad);
    logic [15:0] a, d;
    n_rd = 0;
    n_wr = 0;
    bad  = (op == 2'b11) || ((op == 2'b01) ? (t > 37) : (t > b || b > 37));
    exp_err.push_back(bad);
    if (bad) return;
    if (op == 2'b00) begin
      for (int r = t; r < b; r++)
        for (int k = 0; k < RW; k++) begin
          a = word_adr(r + 1, k);
          d = model_mem[a[15:1]];
          exp_bus.push_back('{1'b0, a, 16'h0});
          push_wr(r, k, d);
          n_rd++;
          n_wr++;
        end
      for (int k = 0; k < RW; k++) begin push_wr(b, k, {f, f}); n_wr++; end
    end else begin
      for (int r = t; r <= ((op == 2'b01) ? t : b); r++)
        for (int k = 0; k < RW; k++) begin push_wr(r, k, {f, f}); n_wr++; end
    end
  endtask

  // ---------------- Monitor ----------------
  int          rd_seen = 0, wr_seen = 0, done_seen = 0;
  int unsigned done_cycle = 0;
  bit          in_cyc = 0, gap_pend = 0, done_pend = 0;
  logic [15:0] st_adr, st_dat;
  logic        st_we;

  always @(negedge clk) begin
    bus_t e;
    bit   ee;
    if (rst) begin
      in_cyc    = 0;
      gap_pend  = 0;
      done_pend = 0;
    end else begin
      if (gap_pend) begin
        chk(!m_cyc_o, "idle_gap", 32'(m_cyc_o), 0);
        gap_pend = 0;
      end
      if (done_pend) begin
        chk(!done && cmd_ready, "done_pulse_ready", {30'd0, done, cmd_ready}, 1);
        done_pend = 0;
      end
      if (m_cyc_o && !in_cyc) begin
        in_cyc = 1;
        st_adr = m_adr_o;
        st_dat = m_dat_o;
        st_we  = m_we_o;
      end
      if (m_cyc_o && m_ack_i) begin
        in_cyc   = 0;
        gap_pend = 1;
        if (m_we_o) wr_seen++; else rd_seen++;
        chk(m_stb_o && m_sel_o == 2'b11, "stb_sel", {29'd0, m_stb_o, m_sel_o}, 32'h7);
        chk(m_adr_o == st_adr && m_we_o == st_we && (!m_we_o || m_dat_o == st_dat),
            "bus_hold", {m_adr_o, m_dat_o}, {st_adr, st_dat});
        if (exp_bus.size() == 0) begin
          chk(0, "unexpected_bus", {15'd0, m_we_o, m_adr_o}, 0);
        end else begin
          e = exp_bus.pop_front();
          chk(m_we_o == e.we && m_adr_o == e.adr, "bus_adr",
              {15'd0, m_we_o, m_adr_o}, {15'd0, e.we, e.adr});
          if (e.we) chk(m_dat_o == e.dat, "wr_data", 32'(m_dat_o), 32'(e.dat));
        end
      end
      if (done) begin
        done_seen++;
        done_cycle = cyc_count;
        done_pend  = 1;
        if (exp_err.size() == 0) begin
          chk(0, "unexpected_done", 32'(err), 0);
        end else begin
          ee = exp_err.pop_front();
          chk(err == ee, "done_err", 32'(err), 32'(ee));
        end
        chk(exp_bus.size() == 0, "bus_left_at_done", exp_bus.size(), 0);
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic run_cmd(input logic [1:0] op, input int t, input int b,
                         input logic [7:0] f, input bit toggle);
    int n_rd, n_wr, d0, guard;
    int unsigned a_cyc;
    bit bad;
    guard = 0;
    while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
    chk(cmd_ready, "ready_before_cmd", 32'(cmd_ready), 1);
    model_cmd(op, t, b, f, n_rd, n_wr, bad);
    rd_seen   = 0;
    wr_seen   = 0;
    d0        = done_seen;
    cmd_valid = 1'b1;
    cmd_op    = op;
    top_row   = 6'(t);
    bot_row   = 6'(b);
    fill_char = f;
    a_cyc     = cyc_count;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    top_row   = 6'($urandom);
    bot_row   = 6'($urandom);
    fill_char = 8'($urandom);
    chk(!cmd_ready, "busy_after_accept", 32'(cmd_ready), 0);
    guard = 0;
    while (done_seen == d0 && guard < 30000) begin
      if (toggle && !cmd_ready) begin
        cmd_valid = 1'($urandom);
        cmd_op    = 2'($urandom);
        top_row   = 6'($urandom);
        bot_row   = 6'($urandom);
        fill_char = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b0;
    chk(done_seen == d0 + 1, "done_count", done_seen - d0, 1);
    chk(rd_seen == n_rd, "read_count", rd_seen, n_rd);
    chk(wr_seen == n_wr, "write_count", wr_seen, n_wr);
    if (bad) chk(done_cycle == a_cyc + 2, "err_latency", done_cycle - a_cyc, 2);
    $display("cmd op=%0d top=%0d bot=%0d fill=%02h -> reads=%0d writes=%0d err_exp=%0d",
             op, t, b, f, rd_seen, wr_seen, bad);
    @(negedge clk);
  endtask

  initial begin
    int t, b, guard, d0;
    logic [1:0] op;
    model_preload();
    @(negedge clk);
    chk({m_cyc_o, m_stb_o, m_we_o, m_sel_o, done, err} == 7'd0 && m_adr_o == 0 &&
        m_dat_o == 0 && cmd_ready, "reset_state",
        {m_adr_o, 7'd0, m_cyc_o, m_stb_o, m_we_o, done, err, cmd_ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // Scroll rows 1..3 up, vacated row filled with 00.
    fixed_lat = 0;
    run_cmd(2'b00, 1, 3, 8'h00, 1'b0);
    chk(smem[40] == 16'h0202, "scroll_row1", 32'(smem[40]), 32'h0202);
    chk(smem[80 + 39] == 16'h0303, "scroll_row2", 32'(smem[119]), 32'h0303);
    chk(smem[120] == 16'h0000, "scroll_row3", 32'(smem[120]), 0);
    chk(smem[0] == 16'h0000 && smem[160] == 16'h0404, "scroll_untouched",
        {smem[0], smem[160]}, 32'h0000_0404);

    run_cmd(2'b01, 5, 5, 8'h20, 1'b0);
    run_cmd(2'b00, 7, 3, 8'h41, 1'b0);
    run_cmd(2'b11, 2, 4, 8'h41, 1'b0);
    run_cmd(2'b10, 30, 38, 8'h41, 1'b0);
    run_cmd(2'b00, 10, 10, 8'h5A, 1'b0);

    fixed_lat = 5;
    run_cmd(2'b00, 20, 22, 8'h2E, 1'b1);
    fixed_lat = 0;
    run_cmd(2'b10, 0, 37, 8'h61, 1'b0);

    rand_lat = 1'b1;
    for (int n = 0; n < 14; n++) begin
      op = 2'($urandom_range(0, 3));
      t  = $urandom_range(0, 37);
      b  = (op == 2'b01) ? t : t + $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) b = t - 1;
      if (b < 0) b = 0;
      run_cmd(op, t, b, 8'($urandom), n[0]);
    end
    for (int i = 0; i < NWORDS; i++)
      chk(smem[i] == model_mem[i], "memory_image", {16'(i), smem[i]}, {16'(i), model_mem[i]});

    // Reset while a scroll write is waiting for its ack.
    rand_lat  = 1'b0;
    fixed_lat = 5;
    begin
      int n_rd, n_wr;
      bit bad;
      model_cmd(2'b00, 1, 3, 8'h00, n_rd, n_wr, bad);
    end
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    top_row   = 6'd1;
    bot_row   = 6'd3;
    fill_char = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!(m_cyc_o && m_we_o && !m_ack_i) && guard < 200) begin @(negedge clk); guard++; end
    chk(guard < 200, "reach_wr_wait", guard, 0);
    d0 = done_seen;
    #1 rst = 1'b1;
    #1 chk(!m_cyc_o && !m_stb_o, "rst_async_drop", {30'd0, m_cyc_o, m_stb_o}, 0);
    exp_bus.delete();
    exp_err.delete();
    model_preload();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk(cmd_ready, "ready_after_rst", 32'(cmd_ready), 1);
    chk(done_seen == d0, "no_done_after_rst", done_seen - d0, 0);
    fixed_lat = 0;
    run_cmd(2'b01, 2, 2, 8'h7E, 1'b0);
    chk(smem[80] == 16'h7E7E && smem[120] == 16'h0303, "post_rst_clear",
        {smem[80], smem[120]}, 32'h7E7E_0303);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
